// File: rtl/axis_pkt_sink_mem.sv
// axis_pkt_sink_mem
// AXI4-Stream packet sink. Accepted beats are written into an on-chip buffer
// with per-byte-lane enables, packet statistics are tracked per completed
// packet, and the buffer can be read back through a registered random-access
// port (read-first on a same-address collision).
module axis_pkt_sink_mem #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 128,
   parameter int FLOW_MODE   = 1,
   parameter int PKT_RESTART = 1,
   localparam int ADDR_W     = $clog2(DEPTH),
   localparam int KEEP_W     = DATA_WIDTH / 8
) (
   input  logic                  s_axis_aclk,
   input  logic                  s_axis_areset,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_W-1:0]     s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic                  clear,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [ADDR_W:0]       fill_level,
   output logic                  pkt_active,
   output logic                  pkt_done,
   output logic [15:0]           pkt_count,
   output logic [15:0]           last_pkt_len,
   output logic                  overflow
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RECV    = 2'd1,
      ST_DISCARD = 2'd2
   } state_t;

   localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);
   localparam logic [5:0]      LFSR_SEED  = 6'b000101;
   localparam logic [15:0]     CNT_MAX    = 16'hFFFF;

   // Registered state
   state_t                r_state;
   logic                  r_rst_d;
   logic [5:0]            r_lfsr;
   logic [ADDR_W:0]       r_fill;
   logic [15:0]           r_beat_cnt;
   logic [15:0]           r_pkt_count;
   logic [15:0]           r_last_len;
   logic                  r_overflow;
   logic                  r_pkt_done;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // Combinational signals
   state_t                w_state_next;
   logic                  w_full;
   logic                  w_tready;
   logic                  w_accept;
   logic                  w_write;
   logic [ADDR_W-1:0]     w_wr_addr;
   logic [15:0]           w_beat_sat;

   // Buffer is full once DEPTH words have been written since the last restart
   assign w_full     = (r_fill == FULL_LEVEL);
   assign w_accept   = s_axis_tvalid & w_tready;
   // Beats arriving while full are accepted but dropped
   assign w_write    = w_accept & ~w_full;
   assign w_wr_addr  = r_fill[ADDR_W-1:0];
   // Current beat count plus one, pinned at the 16-bit maximum
   assign w_beat_sat = (r_beat_cnt == CNT_MAX) ? CNT_MAX : (r_beat_cnt + 16'd1);

   // Remember that reset was high last cycle so ready stays low one extra cycle
   always_ff @(posedge s_axis_aclk) begin
      r_rst_d <= s_axis_areset;
   end

   // Pseudo-random ready source; advances while the master offers data or ready is low
   always_ff @(posedge s_axis_aclk) begin
      if (s_axis_areset) begin
         r_lfsr <= LFSR_SEED;
      end else if (s_axis_tvalid || !r_lfsr[5]) begin
         r_lfsr <= {r_lfsr[4:0], ~(r_lfsr[5] ^ r_lfsr[4])};
      end
   end

   // Ready depends only on reset, clear and registered state, never on tvalid
   always_comb begin
      w_tready = 1'b0;
      if (!s_axis_areset && !r_rst_d && !clear) begin
         if (FLOW_MODE == 0) begin
            w_tready = 1'b1;
         end else if (FLOW_MODE == 1) begin
            w_tready = r_lfsr[5];
         end else begin
            w_tready = ~w_full;
         end
      end
   end

   // Packet FSM state register
   always_ff @(posedge s_axis_aclk) begin
      if (s_axis_areset || clear) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Packet FSM next-state: only accepted beats move the FSM
   always_comb begin
      w_state_next = r_state;
      if (w_accept) begin
         case (r_state)
            ST_IDLE: begin
               if (!s_axis_tlast) begin
                  w_state_next = ST_RECV;
               end
            end
            ST_RECV: begin
               if (s_axis_tlast) begin
                  w_state_next = ST_IDLE;
               end else if (w_full) begin
                  w_state_next = ST_DISCARD;
               end
            end
            ST_DISCARD: begin
               if (s_axis_tlast) begin
                  w_state_next = ST_IDLE;
               end
            end
            default: begin
               w_state_next = ST_IDLE;
            end
         endcase
      end
   end

   // Fill pointer, beat counter and per-packet status
   always_ff @(posedge s_axis_aclk) begin
      if (s_axis_areset || clear) begin
         r_fill      <= '0;
         r_beat_cnt  <= '0;
         r_pkt_count <= '0;
         r_last_len  <= '0;
         r_overflow  <= 1'b0;
         r_pkt_done  <= 1'b0;
      end else begin
         r_pkt_done <= 1'b0;
         if (w_accept) begin
            if (w_full) begin
               r_overflow <= 1'b1;
            end else begin
               r_fill <= r_fill + 1'b1;
            end
            if (s_axis_tlast) begin
               r_pkt_count <= r_pkt_count + 16'd1;
               r_last_len  <= w_beat_sat;
               r_beat_cnt  <= '0;
               r_pkt_done  <= 1'b1;
               // Restart mode rewinds the buffer for the next packet
               if (PKT_RESTART != 0) begin
                  r_fill <= '0;
               end
            end else begin
               r_beat_cnt <= w_beat_sat;
            end
         end
      end
   end

   // Buffer write with per-byte-lane enables
   always_ff @(posedge s_axis_aclk) begin
      for (int i = 0; i < KEEP_W; i++) begin
         if (w_write && s_axis_tkeep[i]) begin
            r_mem[w_wr_addr][i*8 +: 8] <= s_axis_tdata[i*8 +: 8];
         end
      end
   end

   // Registered read port; a same-cycle write to the address returns old data
   always_ff @(posedge s_axis_aclk) begin
      if (s_axis_areset) begin
         r_rd_data <= '0;
      end else begin
         r_rd_data <= r_mem[rd_addr];
      end
   end

   assign s_axis_tready = w_tready;
   assign rd_data       = r_rd_data;
   assign fill_level    = r_fill;
   assign pkt_active    = (r_state != ST_IDLE);
   assign pkt_done      = r_pkt_done;
   assign pkt_count     = r_pkt_count;
   assign last_pkt_len  = r_last_len;
   assign overflow      = r_overflow;

endmodule

// File: tb/tb_axis_pkt_sink_mem.sv
// tb_axis_pkt_sink_mem
// Directed bench for axis_pkt_sink_mem with three instances:
//   A: always-ready, DEPTH 8, restart per packet
//   B: LFSR ready, DEPTH 256, contiguous
//   C: ready-drops-when-full, DEPTH 8, contiguous
module tb_axis_pkt_sink_mem;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance A
   logic [31:0] a_tdata = '0;
   logic [3:0]  a_tkeep = '0;
   logic        a_tvalid = 1'b0;
   logic        a_tlast = 1'b0;
   logic        a_clear = 1'b0;
   logic [2:0]  a_rd_addr = '0;
   logic        a_tready;
   logic [31:0] a_rd_data;
   logic [3:0]  a_fill;
   logic        a_active, a_done, a_ovf;
   logic [15:0] a_cnt, a_len;

   // Instance B
   logic [31:0] b_tdata = '0;
   logic [3:0]  b_tkeep = 4'hF;
   logic        b_tvalid = 1'b0;
   logic        b_tlast = 1'b0;
   logic        b_clear = 1'b0;
   logic [7:0]  b_rd_addr = '0;
   logic        b_tready;
   logic [31:0] b_rd_data;
   logic [8:0]  b_fill;
   logic        b_active, b_done, b_ovf;
   logic [15:0] b_cnt, b_len;

   // Instance C
   logic [31:0] c_tdata = '0;
   logic [3:0]  c_tkeep = 4'hF;
   logic        c_tvalid = 1'b0;
   logic        c_tlast = 1'b0;
   logic        c_clear = 1'b0;
   logic [2:0]  c_rd_addr = '0;
   logic        c_tready;
   logic [31:0] c_rd_data;
   logic [3:0]  c_fill;
   logic        c_active, c_done, c_ovf;
   logic [15:0] c_cnt, c_len;

   axis_pkt_sink_mem #(.DATA_WIDTH(32), .DEPTH(8), .FLOW_MODE(0), .PKT_RESTART(1)) dut_a (
      .s_axis_aclk(clk), .s_axis_areset(rst),
      .s_axis_tdata(a_tdata), .s_axis_tkeep(a_tkeep), .s_axis_tvalid(a_tvalid),
      .s_axis_tready(a_tready), .s_axis_tlast(a_tlast), .clear(a_clear),
      .rd_addr(a_rd_addr), .rd_data(a_rd_data), .fill_level(a_fill),
      .pkt_active(a_active), .pkt_done(a_done), .pkt_count(a_cnt),
      .last_pkt_len(a_len), .overflow(a_ovf)
   );

   axis_pkt_sink_mem #(.DATA_WIDTH(32), .DEPTH(256), .FLOW_MODE(1), .PKT_RESTART(0)) dut_b (
      .s_axis_aclk(clk), .s_axis_areset(rst),
      .s_axis_tdata(b_tdata), .s_axis_tkeep(b_tkeep), .s_axis_tvalid(b_tvalid),
      .s_axis_tready(b_tready), .s_axis_tlast(b_tlast), .clear(b_clear),
      .rd_addr(b_rd_addr), .rd_data(b_rd_data), .fill_level(b_fill),
      .pkt_active(b_active), .pkt_done(b_done), .pkt_count(b_cnt),
      .last_pkt_len(b_len), .overflow(b_ovf)
   );

   axis_pkt_sink_mem #(.DATA_WIDTH(32), .DEPTH(8), .FLOW_MODE(2), .PKT_RESTART(0)) dut_c (
      .s_axis_aclk(clk), .s_axis_areset(rst),
      .s_axis_tdata(c_tdata), .s_axis_tkeep(c_tkeep), .s_axis_tvalid(c_tvalid),
      .s_axis_tready(c_tready), .s_axis_tlast(c_tlast), .clear(c_clear),
      .rd_addr(c_rd_addr), .rd_data(c_rd_data), .fill_level(c_fill),
      .pkt_active(c_active), .pkt_done(c_done), .pkt_count(c_cnt),
      .last_pkt_len(c_len), .overflow(c_ovf)
   );

   // Offer one beat to A and return #1 after the accepting edge
   task automatic a_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      int n;
      @(negedge clk);
      a_tdata = d; a_tkeep = k; a_tlast = l; a_tvalid = 1'b1;
      n = 0;
      #1;
      while (a_tready !== 1'b1 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      checks++;
      if (a_tready !== 1'b1) begin
         errors++;
         $display("FAIL a_handshake: tready=%b, required 1 within 20 cycles", a_tready);
      end
      @(posedge clk); #1;
      a_tvalid = 1'b0; a_tlast = 1'b0;
      $display("A beat data=%h keep=%h last=%b fill=%0d", d, k, l, a_fill);
   endtask

   // Offer one beat to C and return #1 after the accepting edge
   task automatic c_beat(input logic [31:0] d, input logic l);
      int n;
      @(negedge clk);
      c_tdata = d; c_tkeep = 4'hF; c_tlast = l; c_tvalid = 1'b1;
      n = 0;
      #1;
      while (c_tready !== 1'b1 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      checks++;
      if (c_tready !== 1'b1) begin
         errors++;
         $display("FAIL c_handshake: tready=%b, required 1 within 20 cycles", c_tready);
      end
      @(posedge clk); #1;
      c_tvalid = 1'b0; c_tlast = 1'b0;
      $display("C beat data=%h last=%b fill=%0d", d, l, c_fill);
   endtask

   // Registered read from instance 0=A, 1=B, 2=C
   task automatic rd(input int which, input int addr, output logic [31:0] d);
      @(negedge clk);
      case (which)
         0:       a_rd_addr = addr[2:0];
         1:       b_rd_addr = addr[7:0];
         default: c_rd_addr = addr[2:0];
      endcase
      @(posedge clk); #1;
      case (which)
         0:       d = a_rd_data;
         1:       d = b_rd_data;
         default: d = c_rd_data;
      endcase
      $display("read dut%0d addr=%0d data=%h", which, addr, d);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (a_tready !== 1'b0) begin errors++; $display("FAIL reset_tready_during: got %b need 0", a_tready); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (a_tready !== 1'b0) begin errors++; $display("FAIL reset_tready_after: got %b need 0", a_tready); end
      checks++; if (a_fill !== 4'd0) begin errors++; $display("FAIL reset_fill: got %0d need 0", a_fill); end
      checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL reset_pkt_count: got %0d need 0", a_cnt); end
      checks++; if (a_len !== 16'd0) begin errors++; $display("FAIL reset_last_len: got %0d need 0", a_len); end
      checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b need 0", a_ovf); end
      checks++; if (a_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b need 0", a_active); end
      checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b need 0", a_done); end
      checks++; if (a_rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h need 0", a_rd_data); end
      @(negedge clk); #1;
      checks++; if (a_tready !== 1'b1) begin errors++; $display("FAIL reset_tready_ready: got %b need 1", a_tready); end
      checks++; if (c_tready !== 1'b1) begin errors++; $display("FAIL reset_c_tready: got %b need 1", c_tready); end
      $display("test_reset done");
   endtask

   task automatic test_basic();
      logic [31:0] d;
      logic [31:0] exp;
      a_beat(32'h11, 4'hF, 1'b0);
      checks++; if (a_active !== 1'b1) begin errors++; $display("FAIL basic_active: got %b need 1", a_active); end
      checks++; if (a_fill !== 4'd1) begin errors++; $display("FAIL basic_fill1: got %0d need 1", a_fill); end
      a_beat(32'h22, 4'hF, 1'b0);
      a_beat(32'h33, 4'hF, 1'b0);
      a_beat(32'h44, 4'hF, 1'b1);
      checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b need 1", a_done); end
      checks++; if (a_cnt !== 16'd1) begin errors++; $display("FAIL basic_pkt_count: got %0d need 1", a_cnt); end
      checks++; if (a_len !== 16'd4) begin errors++; $display("FAIL basic_last_len: got %0d need 4", a_len); end
      checks++; if (a_fill !== 4'd0) begin errors++; $display("FAIL basic_fill_restart: got %0d need 0", a_fill); end
      checks++; if (a_active !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b need 0", a_active); end
      @(posedge clk); #1;
      checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b need 0", a_done); end
      for (int i = 0; i < 4; i++) begin
         exp = 32'h11 * (i + 1);
         rd(0, i, d);
         checks++; if (d !== exp) begin errors++; $display("FAIL basic_mem[%0d]: got %h need %h", i, d, exp); end
      end
      $display("test_basic done");
   endtask

   task automatic test_tkeep();
      logic [31:0] d;
      a_beat(32'h11223344, 4'hF, 1'b1);
      @(negedge clk);
      a_rd_addr = 3'd0;
      a_beat(32'hAABBCCDD, 4'h3, 1'b1);
      checks++; if (a_rd_data !== 32'h11223344) begin errors++; $display("FAIL tkeep_read_first: got %h need 11223344", a_rd_data); end
      checks++; if (a_cnt !== 16'd3) begin errors++; $display("FAIL tkeep_pkt_count: got %0d need 3", a_cnt); end
      checks++; if (a_len !== 16'd1) begin errors++; $display("FAIL tkeep_last_len: got %0d need 1", a_len); end
      checks++; if (a_active !== 1'b0) begin errors++; $display("FAIL tkeep_single_idle: got %b need 0", a_active); end
      rd(0, 0, d);
      checks++; if (d !== 32'h1122CCDD) begin errors++; $display("FAIL tkeep_merge: got %h need 1122ccdd", d); end
      $display("test_tkeep done");
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      for (int i = 0; i < 10; i++) begin
         a_beat(32'h100 + i, 4'hF, (i == 9));
         if (i == 7) begin
            checks++; if (a_fill !== 4'd8) begin errors++; $display("FAIL ovf_fill8: got %0d need 8", a_fill); end
            checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL ovf_not_yet: got %b need 0", a_ovf); end
         end
         if (i == 8) begin
            checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b need 1", a_ovf); end
            checks++; if (a_active !== 1'b1) begin errors++; $display("FAIL ovf_discard_active: got %b need 1", a_active); end
            checks++; if (a_fill !== 4'd8) begin errors++; $display("FAIL ovf_fill_hold: got %0d need 8", a_fill); end
         end
      end
      checks++; if (a_len !== 16'd10) begin errors++; $display("FAIL ovf_last_len: got %0d need 10", a_len); end
      checks++; if (a_cnt !== 16'd4) begin errors++; $display("FAIL ovf_pkt_count: got %0d need 4", a_cnt); end
      checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b need 1", a_ovf); end
      checks++; if (a_fill !== 4'd0) begin errors++; $display("FAIL ovf_fill_restart: got %0d need 0", a_fill); end
      checks++; if (a_active !== 1'b0) begin errors++; $display("FAIL ovf_idle: got %b need 0", a_active); end
      for (int i = 0; i < 8; i++) begin
         rd(0, i, d);
         checks++; if (d !== 32'h100 + i) begin errors++; $display("FAIL ovf_mem[%0d]: got %h need %h", i, d, 32'h100 + i); end
      end
      $display("test_overflow done");
   endtask

   task automatic test_flow_full();
      logic [31:0] d;
      for (int k = 0; k < 8; k++) begin
         c_beat(32'hC0 + k, ((k % 3) == 2));
         if (k == 5) begin
            checks++; if (c_cnt !== 16'd2) begin errors++; $display("FAIL full_pkt_count2: got %0d need 2", c_cnt); end
            checks++; if (c_len !== 16'd3) begin errors++; $display("FAIL full_last_len: got %0d need 3", c_len); end
            checks++; if (c_fill !== 4'd6) begin errors++; $display("FAIL full_fill6: got %0d need 6", c_fill); end
         end
      end
      checks++; if (c_tready !== 1'b0) begin errors++; $display("FAIL full_tready_low: got %b need 0", c_tready); end
      checks++; if (c_fill !== 4'd8) begin errors++; $display("FAIL full_fill8: got %0d need 8", c_fill); end
      checks++; if (c_ovf !== 1'b0) begin errors++; $display("FAIL full_no_overflow: got %b need 0", c_ovf); end
      checks++; if (c_active !== 1'b1) begin errors++; $display("FAIL full_active: got %b need 1", c_active); end
      @(negedge clk);
      c_tdata = 32'hC8; c_tlast = 1'b1; c_tvalid = 1'b1;
      for (int n = 0; n < 3; n++) begin
         #1;
         checks++; if (c_tready !== 1'b0) begin errors++; $display("FAIL full_hold[%0d]: got %b need 0", n, c_tready); end
         @(negedge clk);
      end
      c_tvalid = 1'b0; c_tlast = 1'b0;
      #1;
      checks++; if (c_fill !== 4'd8) begin errors++; $display("FAIL full_fill_stuck: got %0d need 8", c_fill); end
      checks++; if (c_cnt !== 16'd2) begin errors++; $display("FAIL full_count_stuck: got %0d need 2", c_cnt); end
      @(negedge clk);
      c_clear = 1'b1;
      #1;
      checks++; if (c_tready !== 1'b0) begin errors++; $display("FAIL clear_tready: got %b need 0", c_tready); end
      @(negedge clk);
      c_clear = 1'b0;
      #1;
      checks++; if (c_tready !== 1'b1) begin errors++; $display("FAIL clear_ready_back: got %b need 1", c_tready); end
      checks++; if (c_fill !== 4'd0) begin errors++; $display("FAIL clear_fill: got %0d need 0", c_fill); end
      checks++; if (c_cnt !== 16'd0) begin errors++; $display("FAIL clear_pkt_count: got %0d need 0", c_cnt); end
      checks++; if (c_len !== 16'd0) begin errors++; $display("FAIL clear_last_len: got %0d need 0", c_len); end
      checks++; if (c_active !== 1'b0) begin errors++; $display("FAIL clear_active: got %b need 0", c_active); end
      rd(2, 0, d);
      checks++; if (d !== 32'hC0) begin errors++; $display("FAIL full_mem0: got %h need c0", d); end
      rd(2, 5, d);
      checks++; if (d !== 32'hC5) begin errors++; $display("FAIL full_mem5: got %h need c5", d); end
      rd(2, 7, d);
      checks++; if (d !== 32'hC7) begin errors++; $display("FAIL full_mem7: got %h need c7", d); end
      $display("test_flow_full done");
   endtask

   task automatic test_reset_midpacket();
      logic [31:0] d;
      a_beat(32'hD0, 4'hF, 1'b0);
      a_beat(32'hD1, 4'hF, 1'b0);
      checks++; if (a_active !== 1'b1) begin errors++; $display("FAIL mid_active: got %b need 1", a_active); end
      checks++; if (a_fill !== 4'd2) begin errors++; $display("FAIL mid_fill: got %0d need 2", a_fill); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (a_tready !== 1'b0) begin errors++; $display("FAIL mid_tready_rst: got %b need 0", a_tready); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (a_tready !== 1'b0) begin errors++; $display("FAIL mid_tready_after: got %b need 0", a_tready); end
      checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL mid_pkt_count: got %0d need 0", a_cnt); end
      checks++; if (a_active !== 1'b0) begin errors++; $display("FAIL mid_inactive: got %b need 0", a_active); end
      checks++; if (a_fill !== 4'd0) begin errors++; $display("FAIL mid_fill0: got %0d need 0", a_fill); end
      checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL mid_no_done: got %b need 0", a_done); end
      checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL mid_ovf_cleared: got %b need 0", a_ovf); end
      @(negedge clk); #1;
      checks++; if (a_tready !== 1'b1) begin errors++; $display("FAIL mid_tready_back: got %b need 1", a_tready); end
      a_beat(32'hE0, 4'hF, 1'b0);
      a_beat(32'hE1, 4'hF, 1'b1);
      checks++; if (a_cnt !== 16'd1) begin errors++; $display("FAIL mid_next_count: got %0d need 1", a_cnt); end
      checks++; if (a_len !== 16'd2) begin errors++; $display("FAIL mid_next_len: got %0d need 2", a_len); end
      rd(0, 0, d);
      checks++; if (d !== 32'hE0) begin errors++; $display("FAIL mid_mem0: got %h need e0", d); end
      rd(0, 1, d);
      checks++; if (d !== 32'hE1) begin errors++; $display("FAIL mid_mem1: got %h need e1", d); end
      $display("test_reset_midpacket done");
   endtask

   task automatic test_lfsr();
      logic [5:0]  m;
      logic        first;
      logic        exp_rdy;
      logic        acc;
      int          nacc;
      int          exp_acc;
      logic [31:0] d;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m = 6'b000101;
      first = 1'b1;
      nacc = 0;
      exp_acc = 0;
      b_tdata = 32'd0; b_tlast = 1'b0; b_tkeep = 4'hF; b_tvalid = 1'b1;
      for (int c = 0; c < 200; c++) begin
         #1;
         exp_rdy = first ? 1'b0 : m[5];
         checks++;
         if (b_tready !== exp_rdy) begin
            errors++;
            $display("FAIL lfsr_ready[%0d]: got %b need %b", c, b_tready, exp_rdy);
         end
         acc = b_tready;
         if (exp_rdy) exp_acc++;
         @(posedge clk);
         m = {m[4:0], ~(m[5] ^ m[4])};
         first = 1'b0;
         if (acc === 1'b1) nacc++;
         @(negedge clk);
         b_tdata = nacc;
      end
      b_tvalid = 1'b0;
      $display("B accepted %0d beats, model %0d", nacc, exp_acc);
      #1;
      checks++; if (b_fill !== 9'(exp_acc)) begin errors++; $display("FAIL lfsr_fill: got %0d need %0d", b_fill, exp_acc); end
      checks++; if (b_ovf !== 1'b0) begin errors++; $display("FAIL lfsr_overflow: got %b need 0", b_ovf); end
      checks++; if (b_active !== 1'b1) begin errors++; $display("FAIL lfsr_active: got %b need 1", b_active); end
      for (int i = 0; i < exp_acc; i++) begin
         rd(1, i, d);
         checks++; if (d !== 32'(i)) begin errors++; $display("FAIL lfsr_mem[%0d]: got %h need %h", i, d, 32'(i)); end
      end
      $display("test_lfsr done");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_tkeep();
      test_overflow();
      test_flow_full();
      test_reset_midpacket();
      test_lfsr();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
